// File: rtl/thermo_to_binary_pipe_if.sv
// Valid/ready bus for the thermometer encoder: the input code stream and
// the encoded binary result stream, sized by the thermometer width N.
interface thermo_to_binary_pipe_if #(
  parameter int N = 7
);
  localparam int BW = $clog2(N + 1);

  logic [N-1:0]  in_code;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_bin;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;

  // Encoder side: consumes codes, produces results.
  modport slave (
    input  in_code, in_valid, out_ready,
    output in_ready, out_bin, out_err, out_valid
  );

  // Environment side: supplies codes, consumes results.
  modport master (
    output in_code, in_valid, out_ready,
    input  in_ready, out_bin, out_err, out_valid
  );
endinterface

// File: rtl/thermo_to_binary_pipe.sv
// Two-stage thermometer-to-binary encoder with optional 3-input majority
// bubble correction, illegal-code flagging and valid/ready flow control.
// S1 holds the corrected code; S2 holds the popcount and the error flag.
// A saturating counter tallies errored words handed downstream.
module thermo_to_binary_pipe #(
  parameter int N          = 7,
  parameter bit BUBBLE_FIX = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  thermo_to_binary_pipe_if.slave  bus,
  input  logic                    err_clr,
  output logic [15:0]             err_count
);

  localparam int BW = $clog2(N + 1);

  // Corrected code feeding S1.
  logic [N-1:0]  corr_code;
  logic [N-1:0]  s1_code;
  logic          s1_valid;

  // S1 -> S2 combinational results.
  logic [BW-1:0] pop_count;
  logic          code_bad;

  // S2 registered outputs.
  logic [BW-1:0] bin_q;
  logic          err_q;
  logic          out_valid_q;

  // Handshake terms.
  logic          s2_adv;
  logic          s1_adv;
  logic          in_fire;
  logic          out_fire;

  // ---------------------------------------------------------------------
  // Bubble correction. The code is padded with a forced 1 below bit 0 and
  // a forced 0 above bit N-1 so the end comparators vote like the middle.
  // ---------------------------------------------------------------------
  generate
    if (BUBBLE_FIX) begin : g_fix
      logic [N+1:0] padded;
      assign padded = {1'b0, bus.in_code, 1'b1};

      // Majority of each bit with its two neighbours.
      always_comb begin
        // NOTE: default first so every path assigns corr_code and no latch is inferred.
        corr_code = '0;
        for (int k = 0; k < N; k++) begin
          corr_code[k] = (padded[k]   & padded[k+1]) |
                         (padded[k+1] & padded[k+2]) |
                         (padded[k]   & padded[k+2]);
        end
      end
    end else begin : g_bypass
      assign corr_code = bus.in_code;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Flow control. No skid buffer: in_ready is a combinational function of
  // out_ready through the two advance terms.
  // ---------------------------------------------------------------------
  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !rst;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;

  // ---------------------------------------------------------------------
  // Legality check and popcount on the S1 code. A legal code is a run of
  // ones from bit 0 upward; any 1 sitting above a 0 breaks it.
  // ---------------------------------------------------------------------
  // Count ones and look for a 0->1 step going upward.
  always_comb begin
    pop_count = '0;
    code_bad  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pop_count = pop_count + BW'(s1_code[k]);
    end
    for (int k = 1; k < N; k++) begin
      if (s1_code[k] && !s1_code[k-1]) begin
        code_bad = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: capture the corrected code when the stage can advance.
  // ---------------------------------------------------------------------
  // S1 valid flag and data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      s1_valid <= bus.in_valid;
    end
    // NOTE: s1_code is not reset; s1_valid qualifies it, so reset logic would be wasted.
    if (in_fire) begin
      s1_code <= corr_code;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: register the binary result; hold it while stalled.
  // ---------------------------------------------------------------------
  // S2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        bin_q <= pop_count;
        err_q <= code_bad;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = bin_q;
  assign bus.out_err   = err_q;

  // ---------------------------------------------------------------------
  // Errored-word counter: counts delivered errored words, sticks at the
  // top value, and a clear wins over a same-cycle increment.
  // ---------------------------------------------------------------------
  // Saturating error counter with priority clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_fire && err_q && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_thermo_to_binary_pipe.sv
// Self-checking bench for thermo_to_binary_pipe. Two N=7 encoders (with and
// without bubble correction) share one stimulus stream; an N=15 encoder is
// swept separately. Expected results come from a vote/popcount model.
module tb_thermo_to_binary_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  code7;
  logic        valid7, ready7, clr7;
  logic [14:0] code15;
  logic        valid15, ready15, clr15;
  logic [15:0] ecnt_a, ecnt_b, ecnt_c;

  int n_pass  = 0;
  int n_total = 0;
  int m_ecnt_a = 0;
  int m_ecnt_b = 0;

  logic [2:0] last_a_bin, last_b_bin;
  logic       last_a_err, last_b_err;

  always #5 clk = ~clk;

  thermo_to_binary_pipe_if #(.N(7))  bus_a ();
  thermo_to_binary_pipe_if #(.N(7))  bus_b ();
  thermo_to_binary_pipe_if #(.N(15)) bus_c ();

  assign bus_a.in_code   = code7;
  assign bus_a.in_valid  = valid7;
  assign bus_a.out_ready = ready7;
  assign bus_b.in_code   = code7;
  assign bus_b.in_valid  = valid7;
  assign bus_b.out_ready = ready7;
  assign bus_c.in_code   = code15;
  assign bus_c.in_valid  = valid15;
  assign bus_c.out_ready = ready15;

  thermo_to_binary_pipe #(.N(7), .BUBBLE_FIX(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .err_clr(clr7), .err_count(ecnt_a)
  );
  thermo_to_binary_pipe #(.N(7), .BUBBLE_FIX(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .err_clr(clr7), .err_count(ecnt_b)
  );
  thermo_to_binary_pipe #(.N(15), .BUBBLE_FIX(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave), .err_clr(clr15), .err_count(ecnt_c)
  );

  // ---------------- reference model ----------------
  function automatic logic [14:0] ref_corr(input logic [14:0] t, input int n, input bit fix);
    logic [14:0] c;
    int lo, hi, votes;
    c = '0;
    for (int k = 0; k < n; k++) begin
      if (!fix) begin
        c[k] = t[k];
      end else begin
        lo    = (k == 0)     ? 1 : int'(t[k-1]);
        hi    = (k == n - 1) ? 0 : int'(t[k+1]);
        votes = lo + int'(t[k]) + hi;
        c[k]  = (votes >= 2);
      end
    end
    return c;
  endfunction

  function automatic int ref_pop(input logic [14:0] c);
    int s = 0;
    for (int k = 0; k < 15; k++) s += int'(c[k]);
    return s;
  endfunction

  function automatic bit ref_err(input logic [14:0] c);
    return int'(c) != ((1 << ref_pop(c)) - 1);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // ---------------- N=7 stream driver with inline checks ----------------
  task automatic stream7(input logic [6:0] codes[$], input int stall_pct,
                         input bit clr_on_err, input bit chk_lat);
    int idx = 0;
    int cyc = 0;
    int limit;
    logic [6:0] exp_q[$];
    int acc_q[$];
    bit fire_in, fire_out, ea, eb;
    logic [14:0] ca, cb;
    limit = codes.size() * 20 + 100;
    while ((idx < codes.size() || exp_q.size() != 0) && cyc < limit) begin
      @(negedge clk);
      n_total++;
      if (ecnt_a !== 16'(m_ecnt_a) || ecnt_b !== 16'(m_ecnt_b))
        $display("FAIL err_count got a=%h b=%h want a=%h b=%h", ecnt_a, ecnt_b, 16'(m_ecnt_a), 16'(m_ecnt_b));
      else n_pass++;
      valid7 = (idx < codes.size()) && (int'($urandom_range(99)) >= stall_pct);
      code7  = valid7 ? codes[idx] : 7'($urandom);
      ready7 = (int'($urandom_range(99)) >= stall_pct);
      clr7   = 1'b0;
      #1;
      fire_in  = valid7 && bus_a.in_ready;
      fire_out = bus_a.out_valid && ready7;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_output got bin=%0d want none", bus_a.out_bin);
        end else begin
          ca = ref_corr({8'd0, exp_q[0]}, 7, 1'b1);
          cb = ref_corr({8'd0, exp_q[0]}, 7, 1'b0);
          ea = ref_err(ca);
          eb = ref_err(cb);
          n_total++;
          if (bus_a.out_bin !== 3'(ref_pop(ca)) || bus_a.out_err !== ea)
            $display("FAIL word_fix code=%b got bin=%0d err=%b want bin=%0d err=%b",
                     exp_q[0], bus_a.out_bin, bus_a.out_err, ref_pop(ca), ea);
          else n_pass++;
          n_total++;
          if (bus_b.out_valid !== 1'b1 || bus_b.out_bin !== 3'(ref_pop(cb)) || bus_b.out_err !== eb)
            $display("FAIL word_nofix code=%b got v=%b bin=%0d err=%b want v=1 bin=%0d err=%b",
                     exp_q[0], bus_b.out_valid, bus_b.out_bin, bus_b.out_err, ref_pop(cb), eb);
          else n_pass++;
          if (chk_lat) begin
            n_total++;
            if (cyc - acc_q[0] != 2)
              $display("FAIL latency got %0d want 2", cyc - acc_q[0]);
            else n_pass++;
          end
          last_a_bin = bus_a.out_bin;
          last_a_err = bus_a.out_err;
          last_b_bin = bus_b.out_bin;
          last_b_err = bus_b.out_err;
          if (clr_on_err && ea) clr7 = 1'b1;
          if (clr7) begin
            m_ecnt_a = 0;
            m_ecnt_b = 0;
          end else begin
            if (ea) m_ecnt_a = sat_inc(m_ecnt_a);
            if (eb) m_ecnt_b = sat_inc(m_ecnt_b);
          end
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (fire_in) begin
        exp_q.push_back(codes[idx]);
        acc_q.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    if (cyc >= limit) begin
      n_total++;
      $display("FAIL stream_timeout got %0d words pending want 0", exp_q.size() + codes.size() - idx);
    end
    @(negedge clk);
    valid7 = 1'b0;
    ready7 = 1'b1;
    clr7   = 1'b0;
    n_total++;
    if (ecnt_a !== 16'(m_ecnt_a) || ecnt_b !== 16'(m_ecnt_b))
      $display("FAIL err_count_end got a=%h b=%h want a=%h b=%h", ecnt_a, ecnt_b, 16'(m_ecnt_a), 16'(m_ecnt_b));
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      n_total++;
      if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b0 || bus_a.out_bin !== 3'd0 ||
          bus_a.out_err !== 1'b0 || ecnt_a !== 16'd0)
        $display("FAIL reset_state got rdy=%b v=%b bin=%0d err=%b cnt=%h want 0 0 0 0 0",
                 bus_a.in_ready, bus_a.out_valid, bus_a.out_bin, bus_a.out_err, ecnt_a);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    valid7 = 1'b0;
    valid15 = 1'b0;
    #1;
    n_total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0)
      $display("FAIL reset_release got rdy=%b v=%b want 1 0", bus_a.in_ready, bus_a.out_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus_a.out_valid !== 1'b0)
      $display("FAIL reset_ignored_input got v=%b want 0", bus_a.out_valid);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [6:0] q[$];
    for (int k = 0; k <= 7; k++) q.push_back(7'((1 << k) - 1));
    stream7(q, 0, 1'b0, 1'b1);
    n_total++;
    if (last_a_bin !== 3'd7 || last_a_err !== 1'b0)
      $display("FAIL sweep_top got bin=%0d err=%b want 7 0", last_a_bin, last_a_err);
    else n_pass++;
  endtask

  task automatic test_bubble();
    logic [6:0] q[$];
    q.push_back(7'b0001011);
    stream7(q, 0, 1'b0, 1'b0);
    n_total++;
    if (last_a_bin !== 3'd3 || last_a_err !== 1'b0 || last_b_bin !== 3'd3 || last_b_err !== 1'b1)
      $display("FAIL bubble got fix=%0d/%b nofix=%0d/%b want 3/0 3/1",
               last_a_bin, last_a_err, last_b_bin, last_b_err);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [6:0] q[$];
    int base;
    base = m_ecnt_a;
    q.push_back(7'b1100011);
    stream7(q, 0, 1'b0, 1'b0);
    n_total++;
    if (last_a_bin !== 3'd4 || last_a_err !== 1'b1 || ecnt_a !== 16'(base + 1))
      $display("FAIL illegal got bin=%0d err=%b cnt=%h want 4 1 %h",
               last_a_bin, last_a_err, ecnt_a, 16'(base + 1));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [6:0] seq[3];
    bit exp_ir[5];
    int accepts = 0;
    int got_bin[$];
    int got_cyc[$];
    int cyc = 0;
    seq = '{7'b0000001, 7'b0000011, 7'b0000111};
    exp_ir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ready7 = 1'b0;
      valid7 = (accepts < 3);
      code7  = seq[(accepts < 3) ? accepts : 2];
      #1;
      n_total++;
      if (bus_a.in_ready !== exp_ir[k])
        $display("FAIL bp_in_ready cycle %0d got %b want %b", k, bus_a.in_ready, exp_ir[k]);
      else n_pass++;
      if (k >= 2) begin
        n_total++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_bin !== 3'd1 || bus_a.out_err !== 1'b0)
          $display("FAIL bp_hold cycle %0d got v=%b bin=%0d err=%b want 1 1 0",
                   k, bus_a.out_valid, bus_a.out_bin, bus_a.out_err);
        else n_pass++;
      end
      if (valid7 && bus_a.in_ready) accepts++;
    end
    n_total++;
    if (accepts != 2) $display("FAIL bp_accepts got %0d want 2", accepts);
    else n_pass++;
    while (got_bin.size() < 3 && cyc < 20) begin
      @(negedge clk);
      ready7 = 1'b1;
      valid7 = (accepts < 3);
      code7  = seq[(accepts < 3) ? accepts : 2];
      #1;
      if (bus_a.out_valid) begin
        got_bin.push_back(int'(bus_a.out_bin));
        got_cyc.push_back(cyc);
      end
      if (valid7 && bus_a.in_ready) accepts++;
      cyc++;
    end
    @(negedge clk);
    valid7 = 1'b0;
    n_total++;
    if (got_bin.size() != 3) begin
      $display("FAIL bp_release_count got %0d words want 3", got_bin.size());
    end else if (got_bin[0] != 1 || got_bin[1] != 2 || got_bin[2] != 3 ||
                 got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
      $display("FAIL bp_release_order got %0d,%0d,%0d at %0d,%0d,%0d want 1,2,3 consecutive",
               got_bin[0], got_bin[1], got_bin[2], got_cyc[0], got_cyc[1], got_cyc[2]);
    end else n_pass++;
  endtask

  task automatic test_err_saturate();
    logic [6:0] q[$];
    @(negedge clk);
    clr7 = 1'b1;
    @(negedge clk);
    clr7 = 1'b0;
    m_ecnt_a = 0;
    m_ecnt_b = 0;
    n_total++;
    if (ecnt_a !== 16'd0 || ecnt_b !== 16'd0)
      $display("FAIL err_clr_alone got a=%h b=%h want 0 0", ecnt_a, ecnt_b);
    else n_pass++;
    for (int k = 0; k < 65534; k++) q.push_back(7'b1100011);
    stream7(q, 0, 1'b0, 1'b0);
    n_total++;
    if (ecnt_a !== 16'hFFFE) $display("FAIL err_preload got %h want fffe", ecnt_a);
    else n_pass++;
    q.delete();
    for (int k = 0; k < 3; k++) q.push_back(7'b1100011);
    stream7(q, 0, 1'b0, 1'b0);
    n_total++;
    if (ecnt_a !== 16'hFFFF || ecnt_b !== 16'hFFFF)
      $display("FAIL err_saturate got a=%h b=%h want ffff ffff", ecnt_a, ecnt_b);
    else n_pass++;
  endtask

  task automatic test_err_clr_priority();
    logic [6:0] q[$];
    q.push_back(7'b1100011);
    stream7(q, 0, 1'b1, 1'b0);
    n_total++;
    if (ecnt_a !== 16'd0 || last_a_err !== 1'b1)
      $display("FAIL err_clr_priority got cnt=%h err=%b want 0 1", ecnt_a, last_a_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] q[$];
    for (int k = 0; k < 300; k++) q.push_back(7'($urandom));
    stream7(q, 30, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    logic [6:0] q[$];
    q.push_back(7'b1100011);
    stream7(q, 0, 1'b0, 1'b0);
    @(negedge clk);
    ready7 = 1'b0;
    valid7 = 1'b1;
    code7  = 7'b0000001;
    @(negedge clk);
    code7  = 7'b0000011;
    @(negedge clk);
    #1;
    n_total++;
    if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 || ecnt_a === 16'd0)
      $display("FAIL rst_mid_full got rdy=%b v=%b cnt=%h want 0 1 nonzero",
               bus_a.in_ready, bus_a.out_valid, ecnt_a);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_bin !== 3'd0 || bus_a.out_err !== 1'b0 ||
        ecnt_a !== 16'd0 || bus_a.in_ready !== 1'b0)
      $display("FAIL rst_mid_state got v=%b bin=%0d err=%b cnt=%h rdy=%b want 0 0 0 0 0",
               bus_a.out_valid, bus_a.out_bin, bus_a.out_err, ecnt_a, bus_a.in_ready);
    else n_pass++;
    @(negedge clk);
    rst    = 1'b0;
    valid7 = 1'b0;
    ready7 = 1'b1;
    m_ecnt_a = 0;
    m_ecnt_b = 0;
    #1;
    n_total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0)
      $display("FAIL rst_mid_release got rdy=%b v=%b want 1 0", bus_a.in_ready, bus_a.out_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus_a.out_valid !== 1'b0)
      $display("FAIL rst_mid_discard got v=%b want 0", bus_a.out_valid);
    else n_pass++;
  endtask

  task automatic test_sweep15();
    logic [14:0] codes[$];
    logic [14:0] exp_q[$];
    int acc_q[$];
    logic [14:0] c;
    int idx = 0;
    int cyc = 0;
    for (int k = 0; k <= 15; k++) codes.push_back(15'((1 << k) - 1));
    for (int k = 0; k < 20; k++) codes.push_back(15'($urandom));
    ready15 = 1'b1;
    while ((idx < codes.size() || exp_q.size() != 0) && cyc < 200) begin
      @(negedge clk);
      valid15 = (idx < codes.size());
      code15  = valid15 ? codes[idx] : 15'd0;
      #1;
      if (bus_c.out_valid) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL n15_spurious got bin=%0d want none", bus_c.out_bin);
        end else begin
          c = ref_corr(exp_q[0], 15, 1'b1);
          if (bus_c.out_bin !== 4'(ref_pop(c)) || bus_c.out_err !== ref_err(c) || cyc - acc_q[0] != 2)
            $display("FAIL n15_word code=%b got bin=%0d err=%b lat=%0d want bin=%0d err=%b lat=2",
                     exp_q[0], bus_c.out_bin, bus_c.out_err, cyc - acc_q[0], ref_pop(c), ref_err(c));
          else n_pass++;
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (valid15 && bus_c.in_ready) begin
        exp_q.push_back(codes[idx]);
        acc_q.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    if (cyc >= 200) begin
      n_total++;
      $display("FAIL n15_timeout got %0d pending want 0", exp_q.size() + codes.size() - idx);
    end
    @(negedge clk);
    valid15 = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    code7   = 7'h7F;
    valid7  = 1'b1;
    ready7  = 1'b1;
    clr7    = 1'b0;
    code15  = 15'h7FFF;
    valid15 = 1'b1;
    ready15 = 1'b1;
    clr15   = 1'b0;
    last_a_bin = '0;
    last_b_bin = '0;
    last_a_err = 1'b0;
    last_b_err = 1'b0;
    test_reset();
    test_sweep();
    test_bubble();
    test_illegal();
    test_backpressure();
    test_random();
    test_err_saturate();
    test_err_clr_priority();
    test_reset_midstream();
    test_sweep15();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
